prefix_scan_engine: RTL
=======================

Name: prefix_scan_engine

Overview:
- Parametrised, handshaked prefix-scan engine. It is the successor to the fixed 32-bit, 256-entry sum kernel.
- Holds an input array A and a result array B in internal memories. On start, scans A[0..n-1] and writes B[i] in one of four modes: inclusive sum, exclusive sum, running signed max, running signed min.
- Returns the last written element.
- The host loads A and reads back B through dedicated ports, so the block sits as a compute leaf under the HLS top-level controller.

Parameters:
- DATA_W, 32: element and result width in bits.
- ADDR_W, 8: memory address width.
- DEPTH, 256: entries per memory. Must be ≤ 2^ADDR_W.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- n  in  ADDR_W+1  element count; sampled with start.
- mode  in  2  sampled with start. 00 = inclusive sum, 01 = exclusive sum, 10 = running signed max, 11 = running signed min.
- busy  out  1  high while a scan is in progress (RD/ACC states).
- done  out  1  one-cycle pulse when the scan completes.
- return_val  out  DATA_W  last written B element; held until the next accepted start.
- overflow  out  1  sticky unsigned carry-out from any sum addition in the current scan.
- a_we  in  1  A write enable; honoured only when busy = 0.
- a_addr  in  ADDR_W  A write address.
- a_wdata  in  DATA_W  A write data.
- b_raddr  in  ADDR_W  B read address.
- b_rdata  out  DATA_W  B read data, registered, 1-cycle latency.

Behaviour:
- Reset (sys_rst = 1 at an edge):
  - state goes to IDLE.
  - busy = 0, done = 0, return_val = 0, overflow = 0, b_rdata = 0, index and accumulator = 0.
  - Memories are not cleared.
  - Reset mid-scan aborts immediately; B is left partially written.
- States: IDLE, RD, ACC, FIN.
- Start acceptance:
  - In IDLE with start = 1 at edge T: latch neff = min(n, DEPTH) and mode; clear overflow; clear index i.
  - The next state is RD if neff ≥ 1, otherwise FIN.
  - start is ignored outside IDLE.
- RD: register a_q ← A[i]. Next state is ACC.
- ACC, sum modes:
  - inclusive: acc_new = acc + a_q, write B[i] = acc_new.
  - exclusive: write B[i] = acc, then acc_new = acc + a_q.
  - Addition is modulo 2^DATA_W. A carry-out sets overflow.
  - acc starts at 0.
- ACC, max/min modes:
  - At i = 0, acc_new = a_q. Otherwise acc_new = signed max/min(acc, a_q).
  - Write B[i] = acc_new. overflow stays 0.
- ACC, common: return_val ← the value written. If i = neff−1, next state is FIN; otherwise i ← i+1 and next state is RD.
- FIN: done = 1 for exactly this cycle. Next state is IDLE. If neff = 0, return_val ← 0.
- Timing:
  - busy = 1 exactly during RD/ACC cycles.
  - For start accepted at edge T and neff ≥ 1, done is high during cycle T+2·neff+1.
  - For neff = 0, done is high during cycle T+1.
  - A new start is accepted in the IDLE cycle immediately after FIN.
- Host access:
  - a_we while busy = 1 is dropped.
  - b_rdata ← B[b_raddr] every cycle, including while busy; contents are then partially updated.
  - A write and B read to the same index in IDLE are independent, because A and B are separate memories.
- Exclusive mode, neff = 1: B[0] = 0 and return_val = 0.

Test Plan:
- Load A = {1,2,3,4,5}, start with n = 5, mode = 00. Expect B = {1,3,6,10,15}, return_val = 15, overflow = 0, and done at T+11 with busy high for 10 cycles.
- Same A, mode = 01. Expect B = {0,1,3,6,10} and return_val = 10.
- A = {3, −7, 9, 2, 9} (two's complement): mode = 10 gives B = {3,3,9,9,9}; mode = 11 gives B = {3,−7,−7,−7,−7}.
- DATA_W = 32, A = {0xFFFFFFFF, 0x2}, mode = 00. Expect B = {0xFFFFFFFF, 0x1}, return_val = 1, overflow = 1. A following scan with no carry shows overflow = 0.
- Boundaries:
  - n = 0: done at T+1 with return_val = 0 and no B writes.
  - n = 300 with DEPTH = 256: clamps to 256 elements, done at T+513.
  - start asserted while busy: ignored.
- Abort and lockout: assert sys_rst during the ACC of i = 2. Next cycle busy = 0, done = 0, return_val = 0. a_we pulsed while busy leaves A unchanged, confirmed by a rescan.

Source files
------------

// File: rtl/prefix_scan_engine_if.sv
// Host-side bus of the prefix-scan engine: scan handshake, A-memory write port
// and B-memory read port.
interface prefix_scan_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   n;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] return_val;
  logic              overflow;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [ADDR_W-1:0] b_raddr;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output start, n, mode, a_we, a_addr, a_wdata, b_raddr,
    input  busy, done, return_val, overflow, b_rdata
  );

  modport slave (
    input  start, n, mode, a_we, a_addr, a_wdata, b_raddr,
    output busy, done, return_val, overflow, b_rdata
  );
endinterface

// File: rtl/prefix_scan_engine.sv
// Prefix-scan engine: scans A[0..neff-1] into B as inclusive/exclusive sum or
// running signed max/min, one element per RD/ACC pair of cycles.
module prefix_scan_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic                sys_clk,
  input logic                sys_rst,
  prefix_scan_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, ACC, FIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

  state_t state, state_nxt;

  logic [ADDR_W:0]          neff, idx, n_clamp;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] acc, acc_nxt, wr_val, a_p1;
  logic [DATA_W:0]          sum;
  logic                     carry;
  logic                     busy_c, done_c, b_we;
  logic [DATA_W-1:0]        ret_q, b_rdata_q;
  logic                     ovf_q;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic signed [DATA_W-1:0] smin(
    input logic signed [DATA_W-1:0] x, input logic signed [DATA_W-1:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [DATA_W:0] add_carry(
    input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  assign n_clamp = (bus.n > DEPTH_N) ? DEPTH_N : bus.n;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (n_clamp != '0) ? RD : FIN;
      RD:   state_nxt = ACC;
      ACC:  state_nxt = (idx == neff - ONE_N) ? FIN : RD;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    b_we   = 1'b0;
    case (state)
      RD:  busy_c = 1'b1;
      ACC: begin busy_c = 1'b1; b_we = 1'b1; end
      FIN: done_c = 1'b1;
      default: ;
    endcase
  end

  // RD stage: fetch A[i] into a_p1
  always_ff @(posedge sys_clk) begin
    a_p1 <= mem_a[idx[ADDR_W-1:0]];
    if (bus.a_we && !busy_c) mem_a[bus.a_addr] <= bus.a_wdata;
  end

  // ACC stage: combine accumulator with a_p1; exclusive mode writes the pre-add value
  always_comb begin
    sum     = add_carry(acc, a_p1);
    carry   = sum[DATA_W];
    acc_nxt = $signed(sum[DATA_W-1:0]);
    wr_val  = acc_nxt;
    case (mode_q)
      2'b01: wr_val = acc;
      2'b10: begin
        acc_nxt = (idx == '0) ? a_p1 : smax(acc, a_p1);
        wr_val  = acc_nxt;
      end
      2'b11: begin
        acc_nxt = (idx == '0) ? a_p1 : smin(acc, a_p1);
        wr_val  = acc_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (b_we) mem_b[idx[ADDR_W-1:0]] <= wr_val;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx    <= '0;
      acc    <= '0;
      neff   <= '0;
      mode_q <= '0;
      ret_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          neff   <= n_clamp;
          mode_q <= bus.mode;
          idx    <= '0;
          acc    <= '0;
          ovf_q  <= 1'b0;
        end
        ACC: begin
          acc   <= acc_nxt;
          ret_q <= wr_val;
          if (!mode_q[1] && carry) ovf_q <= 1'b1;
          if (state_nxt == RD) idx <= idx + ONE_N;
        end
        FIN: if (neff == '0) ret_q <= '0;
        default: ;
      endcase
    end
  end

  // Host read port: registered, live even while a scan is rewriting B
  always_ff @(posedge sys_clk) begin
    if (sys_rst) b_rdata_q <= '0;
    else         b_rdata_q <= mem_b[bus.b_raddr];
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.return_val = ret_q;
  assign bus.overflow   = ovf_q;
  assign bus.b_rdata    = b_rdata_q;
endmodule
